// File: rtl/vec_mul_pkg.sv
// Shared parameters, row/lane types and drain state encoding for the vector multiplier.
package vec_mul_pkg;
  localparam int MATRIX_SIZE    = 16;
  localparam int PARTIAL_SUM_BW = 24;
  localparam int ADDRESSSIZE    = 10;
  localparam int FIFO_DEPTH     = 4;
  localparam int ROW_W          = MATRIX_SIZE * PARTIAL_SUM_BW;

  typedef logic signed [PARTIAL_SUM_BW-1:0] lane_t;
  typedef logic [ROW_W-1:0]                 row_t;
  typedef logic [ADDRESSSIZE-1:0]           addr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } drain_state_t;

  // Negative lanes clamp to zero; non-negative lanes pass through untouched.
  function automatic row_t relu_row(input row_t row);
    row_t  clamped;
    lane_t lane;
    clamped = row;
    for (int l = 0; l < MATRIX_SIZE; l++) begin
      lane = row[l*PARTIAL_SUM_BW +: PARTIAL_SUM_BW];
      if (lane < 0) clamped[l*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = '0;
    end
    return clamped;
  endfunction
endpackage

// File: rtl/result_fifo.sv
// Synchronous show-ahead row FIFO; head is a register-array read, push and pop may coincide.
module result_fifo
  import vec_mul_pkg::*;
#(
  parameter int WIDTH = ROW_W,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_clear) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      // A push into a full FIFO is only issued alongside a pop, so it reuses the slot leaving.
      if (i_push) begin
        r_mem[r_wptr[AW-1:0]] <= i_data;
        r_wptr                <= r_wptr + PTR_ONE;
      end
      if (i_pop) r_rptr <= r_rptr + PTR_ONE;
    end
  end

  assign o_data  = r_mem[r_rptr[AW-1:0]];
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
endmodule

// File: rtl/result_drain.sv
// Writeback stage: captures array rows, optional ReLU, buffers them and writes them to results SRAM.
//   state   | meaning
//   ST_IDLE | waiting for start; last job's config/count/overflow held
//   ST_RUN  | accepting rows and draining FIFO to SRAM
//   ST_DONE | single-cycle completion pulse
module result_drain
  import vec_mul_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [ADDRESSSIZE-1:0] i_base_addr,
  input  logic [ADDRESSSIZE-1:0] i_row_count,
  input  logic                   i_relu_en,
  input  logic                   i_valid_in,
  input  logic [ROW_W-1:0]       i_result_in,
  input  logic                   i_wr_ready,
  output logic                   o_wr_en,
  output logic [ADDRESSSIZE-1:0] o_wr_addr,
  output logic [ROW_W-1:0]       o_wr_data,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_overflow,
  output logic [ADDRESSSIZE-1:0] o_rows_written
);
  localparam addr_t ADDR_ONE = 1;

  drain_state_t r_state;
  drain_state_t w_state_nxt;

  addr_t r_base;
  addr_t r_count;
  addr_t r_written;
  addr_t r_accepted;
  logic  r_relu;
  logic  r_overflow;

  logic  w_launch;
  logic  w_running;
  logic  w_fifo_full;
  logic  w_fifo_empty;
  row_t  w_fifo_head;
  row_t  w_row_in;
  logic  w_wr_en;
  logic  w_pop;
  logic  w_push;
  logic  w_drop;
  logic  w_last_pop;

  assign w_launch   = (r_state == ST_IDLE) && i_start;
  assign w_running  = (r_state == ST_RUN);
  assign w_wr_en    = w_running && !w_fifo_empty;
  assign w_pop      = w_wr_en && i_wr_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still takes the row.
  assign w_push     = w_running && i_valid_in && (r_accepted < r_count) && (!w_fifo_full || w_pop);
  assign w_drop     = w_running && i_valid_in && !w_push;
  assign w_last_pop = w_pop && ((r_written + ADDR_ONE) == r_count);
  assign w_row_in   = r_relu ? relu_row(i_result_in) : i_result_in;

  result_fifo #(.WIDTH(ROW_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (w_launch),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_row_in),
    .o_data  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = (r_state != ST_IDLE);
    o_done      = 1'b0;
    case (r_state)
      ST_IDLE: if (i_start) w_state_nxt = (i_row_count == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (w_last_pop) w_state_nxt = ST_DONE;
      ST_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_base     <= '0;
      r_count    <= '0;
      r_relu     <= 1'b0;
      r_written  <= '0;
      r_accepted <= '0;
      r_overflow <= 1'b0;
    end else if (w_launch) begin
      r_base     <= i_base_addr;
      r_count    <= i_row_count;
      r_relu     <= i_relu_en;
      r_written  <= '0;
      r_accepted <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pop)  r_written  <= r_written + ADDR_ONE;
      if (w_push) r_accepted <= r_accepted + ADDR_ONE;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign o_wr_en        = w_wr_en;
  assign o_wr_addr      = r_base + r_written;
  assign o_wr_data      = w_fifo_head;
  assign o_overflow     = r_overflow;
  assign o_rows_written = r_written;
endmodule

// File: tb/tb_result_drain.sv
// Randomized and directed bench for result_drain against a queue-based reference model.
module tb_result_drain;
  import vec_mul_pkg::*;

  localparam int W = ROW_W;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start = 1'b0;
  logic [ADDRESSSIZE-1:0] base_addr = '0;
  logic [ADDRESSSIZE-1:0] row_count = '0;
  logic                   relu_en = 1'b0;
  logic                   valid_in = 1'b0;
  logic [ROW_W-1:0]       result_in = '0;
  logic                   wr_ready = 1'b1;
  logic                   wr_en;
  logic [ADDRESSSIZE-1:0] wr_addr;
  logic [ROW_W-1:0]       wr_data;
  logic                   busy;
  logic                   done;
  logic                   overflow;
  logic [ADDRESSSIZE-1:0] rows_written;

  always #5 clk = ~clk;

  result_drain dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_base_addr    (base_addr),
    .i_row_count    (row_count),
    .i_relu_en      (relu_en),
    .i_valid_in     (valid_in),
    .i_result_in    (result_in),
    .i_wr_ready     (wr_ready),
    .o_wr_en        (wr_en),
    .o_wr_addr      (wr_addr),
    .o_wr_data      (wr_data),
    .o_busy         (busy),
    .o_done         (done),
    .o_overflow     (overflow),
    .o_rows_written (rows_written)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: job phase, row queue and counters.
  int   m_phase = 0;  // 0 idle, 1 run, 2 done
  row_t m_q[$];
  int   m_base = 0, m_count = 0, m_written = 0, m_accepted = 0;
  bit   m_relu = 0, m_ovf = 0, m_after_rst = 0;

  int   log_addr[$];
  row_t log_data[$];
  int   done_cnt = 0;

  function automatic row_t ref_relu(input row_t r, input bit en);
    row_t o;
    int   lane;
    o = r;
    for (int l = 0; l < MATRIX_SIZE; l++) begin
      lane = int'($signed(r[l*PARTIAL_SUM_BW +: PARTIAL_SUM_BW]));
      if (en && lane < 0) o[l*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = '0;
    end
    return o;
  endfunction

  function automatic row_t rand_row();
    row_t r;
    for (int k = 0; k < ROW_W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_edge();
    bit pop, take;
    if (rst) begin
      m_phase = 0; m_q.delete();
      m_base = 0; m_count = 0; m_written = 0; m_accepted = 0;
      m_relu = 0; m_ovf = 0; m_after_rst = 1;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_base = int'(base_addr); m_count = int'(row_count); m_relu = relu_en;
          m_written = 0; m_accepted = 0; m_ovf = 0; m_q.delete(); m_after_rst = 0;
          m_phase = (row_count == 0) ? 2 : 1;
        end
        1: begin
          pop  = (m_q.size() > 0) && wr_ready;
          take = valid_in && (m_accepted < m_count) && ((m_q.size() < FIFO_DEPTH) || pop);
          if (pop) begin
            void'(m_q.pop_front());
            m_written++;
          end
          if (take) begin
            m_q.push_back(ref_relu(result_in, m_relu));
            m_accepted++;
          end else if (valid_in) begin
            m_ovf = 1;
          end
          if (m_written == m_count) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic step();
    bit e_wr_en;
    if (wr_en && wr_ready) begin
      log_addr.push_back(int'(wr_addr));
      log_data.push_back(wr_data);
    end
    @(posedge clk);
    model_edge();
    #1;
    e_wr_en = (m_phase == 1) && (m_q.size() > 0);
    chk("wr_en", W'(wr_en), W'(e_wr_en));
    chk("wr_addr", W'(wr_addr), W'((m_base + m_written) % (1 << ADDRESSSIZE)));
    chk("busy", W'(busy), W'(m_phase != 0));
    chk("done", W'(done), W'(m_phase == 2));
    chk("overflow", W'(overflow), W'(m_ovf));
    chk("rows_written", W'(rows_written), W'(m_written));
    if (e_wr_en) chk("wr_data", wr_data, m_q[0]);
    else if (m_after_rst) chk("wr_data_rst", wr_data, '0);
    if (done) done_cnt++;
  endtask

  task automatic job_start(input int b, input int c, input bit r);
    base_addr = ADDRESSSIZE'(b);
    row_count = ADDRESSSIZE'(c);
    relu_en   = r;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic push_row(input row_t r);
    valid_in  = 1'b1;
    result_in = r;
    step();
    valid_in  = 1'b0;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (m_phase != 0 && n < max) begin
      step();
      n++;
    end
    if (m_phase != 0) chk("timeout", W'(1), W'(0));
  endtask

  task automatic clear_logs();
    log_addr.delete();
    log_data.delete();
    done_cnt = 0;
  endtask

  row_t rows[8];
  row_t rr, ex;

  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    // back-to-back rows, plain pass-through
    clear_logs();
    wr_ready = 1'b1;
    job_start('h3F0, 4, 0);
    for (int i = 0; i < 4; i++) begin
      rows[i] = rand_row();
      push_row(rows[i]);
    end
    drain(20);
    chk("t1_nwrites", W'(log_addr.size()), W'(4));
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      chk("t1_addr", W'(log_addr[i]), W'('h3F0 + i));
      chk("t1_data", log_data[i], rows[i]);
    end
    chk("t1_done_cnt", W'(done_cnt), W'(1));
    chk("t1_rows", W'(rows_written), W'(4));

    // ReLU lanes
    clear_logs();
    rr = '0;
    for (int l = 0; l < MATRIX_SIZE; l++) rr[l*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = 24'h800000;
    rr[0 +: PARTIAL_SUM_BW]              = 24'hFFFFFF;
    rr[PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = 24'h000005;
    ex = '0;
    ex[PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = 24'h000005;
    job_start('h100, 1, 1);
    push_row(rr);
    drain(20);
    chk("t2_nwrites", W'(log_data.size()), W'(1));
    if (log_data.size() > 0) chk("t2_relu", log_data[0], ex);

    // overflow with stalled SRAM
    clear_logs();
    wr_ready = 1'b0;
    job_start('h020, 8, 0);
    for (int i = 0; i < 6; i++) begin
      rows[i] = rand_row();
      push_row(rows[i]);
    end
    chk("t3_ovf", W'(overflow), W'(1));
    wr_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("t3_nwrites", W'(log_data.size()), W'(4));
    for (int i = 0; i < 4 && i < log_data.size(); i++) chk("t3_order", log_data[i], rows[i]);
    chk("t3_no_done", W'(done_cnt), W'(0));
    chk("t3_busy", W'(busy), W'(1));
    for (int i = 0; i < 4; i++) push_row(rand_row());
    drain(20);
    chk("t3_rows", W'(rows_written), W'(8));
    chk("t3_ovf_hold", W'(overflow), W'(1));

    // address wrap
    clear_logs();
    job_start('h3FE, 3, 0);
    for (int i = 0; i < 3; i++) push_row(rand_row());
    drain(20);
    chk("t4_nwrites", W'(log_addr.size()), W'(3));
    if (log_addr.size() == 3) begin
      chk("t4_addr0", W'(log_addr[0]), W'('h3FE));
      chk("t4_addr1", W'(log_addr[1]), W'('h3FF));
      chk("t4_addr2", W'(log_addr[2]), W'('h000));
    end

    // push into full FIFO with same-cycle pop
    clear_logs();
    wr_ready = 1'b0;
    job_start('h040, 6, 0);
    for (int i = 0; i < 4; i++) push_row(rand_row());
    wr_ready = 1'b1;
    push_row(rand_row());
    chk("t5_no_ovf", W'(overflow), W'(0));
    push_row(rand_row());
    drain(20);
    chk("t5_ovf_end", W'(overflow), W'(0));
    chk("t5_rows", W'(rows_written), W'(6));

    // reset mid-job
    clear_logs();
    wr_ready = 1'b0;
    job_start('h080, 5, 0);
    push_row(rand_row());
    push_row(rand_row());
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_wr_en", W'(wr_en), W'(0));
    chk("t6_busy", W'(busy), W'(0));
    clear_logs();
    wr_ready = 1'b1;
    step();
    chk("t6_no_write", W'(log_addr.size()), W'(0));
    job_start('h0C0, 1, 0);
    push_row(rand_row());
    drain(20);
    chk("t6_rows", W'(rows_written), W'(1));
    chk("t6_addr", W'(log_addr.size() > 0 ? log_addr[0] : -1), W'('h0C0));

    // randomized jobs
    for (int j = 0; j < 12; j++) begin
      job_start(int'($urandom_range(0, 1023)), int'($urandom_range(0, 9)), bit'($urandom_range(0, 1)));
      for (int n = 0; n < 400 && m_phase != 0; n++) begin
        valid_in  = ($urandom_range(0, 2) != 0);
        result_in = rand_row();
        wr_ready  = ($urandom_range(0, 3) != 0);
        start     = ($urandom_range(0, 15) == 0);
        step();
      end
      start = 1'b0;
      if (m_phase != 0) chk("rand_timeout", W'(1), W'(0));
      for (int n = 0; n < 3; n++) begin
        valid_in  = 1'b1;
        result_in = rand_row();
        step();
      end
      valid_in = 1'b0;
      wr_ready = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
